// File: rtl/pu_or1k_pfpu_f2i_full.sv
// pfpu float-to-integer converter: unpack/classify in stage1,
// align/round/saturate/negate in stage2, both gated by adv_i.
module pu_or1k_pfpu_f2i_full #(
   parameter int EXP_W  = 11,
   parameter int FRAC_W = 52,
   parameter int INT_W  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    adv_i,
   input  logic                    start_i,
   input  logic [EXP_W+FRAC_W:0]   opa_i,
   input  logic [1:0]              rmode_i,
   input  logic                    unsigned_i,
   output logic                    f2i_rdy_o,
   output logic [INT_W-1:0]        f2i_int_o,
   output logic                    f2i_inv_o,
   output logic                    f2i_inx_o,
   output logic                    f2i_snan_o
);

   localparam int BIAS    = (1 << (EXP_W-1)) - 1;
   localparam int SH_W    = $clog2(INT_W+FRAC_W+4);
   localparam int M_W     = INT_W + 1;
   localparam int X_W     = 2*FRAC_W + 4;
   localparam int E_MAX   = INT_W - FRAC_W - 1;
   localparam int SHR_MAX = FRAC_W + 3;

   localparam logic [M_W-1:0]   SMAX_M  = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic [M_W-1:0]   SMIN_M  = {2'b01, {(INT_W-1){1'b0}}};
   localparam logic [INT_W-1:0] POS_MAX = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic [INT_W-1:0] NEG_MIN = {1'b1, {(INT_W-1){1'b0}}};

   // ---------------- stage1: unpack and classify
   logic              sgn_w;
   logic [EXP_W-1:0]  exp_w;
   logic [FRAC_W-1:0] frac_w;
   logic [EXP_W-1:0]  eexp_w;
   int                e_w;
   logic [SH_W-1:0]   sh_w;
   logic              nan_w;
   logic              snan_w;
   logic              ovf_w;

   assign {sgn_w, exp_w, frac_w} = opa_i;
   assign eexp_w = (exp_w == '0) ? EXP_W'(1) : exp_w;
   assign e_w    = int'(eexp_w) - BIAS - FRAC_W;
   assign nan_w  = (&exp_w) & (|frac_w);
   assign snan_w = nan_w & ~frac_w[FRAC_W-1];
   assign ovf_w  = (&exp_w) | (e_w > E_MAX);

   always_comb begin
      sh_w = '0;
      if (e_w < 0)
         sh_w = (-e_w > SHR_MAX) ? SH_W'(SHR_MAX) : SH_W'(-e_w);
      else if (e_w <= E_MAX)
         sh_w = SH_W'(e_w);
   end

   logic              v1_q;
   logic              sgn_q;
   logic [1:0]        rmode_q;
   logic              uns_q;
   logic              nan_q;
   logic              snan_q;
   logic              ovf_q;
   logic              right_q;
   logic [SH_W-1:0]   sh_q;
   logic [FRAC_W:0]   m_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         sgn_q   <= 1'b0;
         rmode_q <= 2'b00;
         uns_q   <= 1'b0;
         nan_q   <= 1'b0;
         snan_q  <= 1'b0;
         ovf_q   <= 1'b0;
         right_q <= 1'b0;
         sh_q    <= '0;
         m_q     <= '0;
      end else begin
         if (flush_i)
            v1_q <= 1'b0;
         else if (adv_i)
            v1_q <= start_i;
         if (adv_i) begin
            sgn_q   <= sgn_w;
            rmode_q <= rmode_i;
            uns_q   <= unsigned_i;
            nan_q   <= nan_w;
            snan_q  <= snan_w;
            ovf_q   <= ovf_w;
            right_q <= (e_w < 0);
            sh_q    <= sh_w;
            m_q     <= {(exp_w != '0), frac_w};
         end
      end
   end

   // ---------------- stage2: align, round, saturate, negate
   logic [X_W-1:0]   x_w;
   logic [M_W-1:0]   mpre_w;
   logic [M_W-1:0]   mag_w;
   logic             g_w;
   logic             s_w;
   logic             inc_w;
   logic [INT_W-1:0] res_w;
   logic             inv_w;
   logic             inx_w;

   assign x_w    = {m_q, {(FRAC_W+3){1'b0}}} >> sh_q;
   assign g_w    = right_q & x_w[FRAC_W+2];
   assign s_w    = right_q & (|x_w[FRAC_W+1:0]);
   assign mpre_w = right_q ? M_W'(x_w[X_W-1:FRAC_W+3])
                           : M_W'(m_q) << sh_q;

   always_comb begin
      inc_w = 1'b0;
      unique case (rmode_q)
         2'b00: inc_w = g_w & (s_w | mpre_w[0]);
         2'b01: inc_w = 1'b0;
         2'b10: inc_w = ~sgn_q & (g_w | s_w);
         2'b11: inc_w = sgn_q & (g_w | s_w);
      endcase
   end

   assign mag_w = mpre_w + M_W'(inc_w);

   always_comb begin
      res_w = '0;
      inv_w = 1'b0;
      if (uns_q) begin
         if (nan_q || (!sgn_q && (ovf_q || mag_w[INT_W]))) begin
            res_w = '1;
            inv_w = 1'b1;
         end else if (sgn_q) begin
            inv_w = ovf_q | (mag_w != '0);
         end else begin
            res_w = mag_w[INT_W-1:0];
         end
      end else begin
         if (nan_q || (!sgn_q && (ovf_q || mag_w > SMAX_M))) begin
            res_w = POS_MAX;
            inv_w = 1'b1;
         end else if (sgn_q && (ovf_q || mag_w > SMIN_M)) begin
            res_w = NEG_MIN;
            inv_w = 1'b1;
         end else if (sgn_q) begin
            res_w = -mag_w[INT_W-1:0];
         end else begin
            res_w = mag_w[INT_W-1:0];
         end
      end
   end

   assign inx_w = (g_w | s_w) & ~inv_w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f2i_rdy_o  <= 1'b0;
         f2i_int_o  <= '0;
         f2i_inv_o  <= 1'b0;
         f2i_inx_o  <= 1'b0;
         f2i_snan_o <= 1'b0;
      end else begin
         if (flush_i)
            f2i_rdy_o <= 1'b0;
         else if (adv_i)
            f2i_rdy_o <= v1_q;
         // results only move when a valid operand advances
         if (adv_i && v1_q) begin
            f2i_int_o  <= res_w;
            f2i_inv_o  <= inv_w;
            f2i_inx_o  <= inx_w;
            f2i_snan_o <= snan_q;
         end
      end
   end

endmodule

// File: tb/tb_pu_or1k_pfpu_f2i_full.sv
// Directed scoreboard bench for the pfpu float-to-integer converter,
// covering the double/64-bit and single/32-bit configurations.
module tb_pu_or1k_pfpu_f2i_full;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] iv;
      logic        inv;
      logic        inx;
      logic        snan;
   } res_t;

   // double -> int64 instance
   logic        flush = 0, adv = 0, start = 0, uns = 0;
   logic [1:0]  rm = 0;
   logic [63:0] opa = 0;
   logic        rdy, inv, inx, snan;
   logic [63:0] iv;

   pu_or1k_pfpu_f2i_full dut (
      .clk(clk), .rst(rst), .flush_i(flush), .adv_i(adv),
      .start_i(start), .opa_i(opa), .rmode_i(rm), .unsigned_i(uns),
      .f2i_rdy_o(rdy), .f2i_int_o(iv), .f2i_inv_o(inv),
      .f2i_inx_o(inx), .f2i_snan_o(snan)
   );

   // single -> int32 instance
   logic        b_adv = 0, b_start = 0, b_uns = 0;
   logic [1:0]  b_rm = 0;
   logic [31:0] b_opa = 0;
   logic        b_rdy, b_inv, b_inx, b_snan;
   logic [31:0] b_iv;

   pu_or1k_pfpu_f2i_full #(.EXP_W(8), .FRAC_W(23), .INT_W(32)) dut_b (
      .clk(clk), .rst(rst), .flush_i(1'b0), .adv_i(b_adv),
      .start_i(b_start), .opa_i(b_opa), .rmode_i(b_rm),
      .unsigned_i(b_uns), .f2i_rdy_o(b_rdy), .f2i_int_o(b_iv),
      .f2i_inv_o(b_inv), .f2i_inx_o(b_inx), .f2i_snan_o(b_snan)
   );

   res_t q[$];
   res_t qb[$];
   int   total = 0;
   int   passed = 0;
   bit   m_v1 = 0, m_rdy = 0;
   bit   mb_v1 = 0, mb_rdy = 0;

   function automatic res_t R(logic [63:0] v, logic a, logic b, logic c);
      return {v, a, b, c};
   endfunction

   task automatic check(string tag, logic [66:0] obs, logic [66:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step(string nm, logic [63:0] o, logic [1:0] r,
                       logic u, logic st, logic ad, logic fl, res_t e);
      res_t x;
      opa = o; rm = r; uns = u; start = st; adv = ad; flush = fl;
      @(posedge clk); #1;
      if (fl) begin
         if (m_v1) void'(q.pop_back());
         m_v1 = 0;
         m_rdy = 0;
      end else if (ad) begin
         m_rdy = m_v1;
         if (m_rdy) begin
            if (q.size() == 0) begin
               check({nm, "_sb_underflow"}, 67'(q.size()), 67'd1);
            end else begin
               x = q.pop_front();
               check({nm, "_data"}, {iv, inv, inx, snan}, x);
            end
         end
         if (st) q.push_back(e);
         m_v1 = st;
      end
      check({nm, "_rdy"}, 67'(rdy), 67'(m_rdy));
   endtask

   task automatic step32(string nm, logic [31:0] o, logic [1:0] r,
                         logic u, logic st, res_t e);
      res_t x;
      b_opa = o; b_rm = r; b_uns = u; b_start = st; b_adv = 1;
      @(posedge clk); #1;
      mb_rdy = mb_v1;
      if (mb_rdy) begin
         if (qb.size() == 0) begin
            check({nm, "_sb_underflow"}, 67'(qb.size()), 67'd1);
         end else begin
            x = qb.pop_front();
            check({nm, "_data"}, {32'h0, b_iv, b_inv, b_inx, b_snan}, x);
         end
      end
      if (st) qb.push_back(e);
      mb_v1 = st;
      check({nm, "_rdy"}, 67'(b_rdy), 67'(mb_rdy));
   endtask

   localparam logic [63:0] PMAX = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] NMIN = 64'h8000_0000_0000_0000;
   localparam res_t        NONE = '0;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", {iv, inv, inx, snan}, 67'd0);
      check("reset_b", {rdy, b_rdy, b_iv, b_inv, b_inx, b_snan}, 67'd0);
      rst = 0;
      @(posedge clk); #1;

      step("p1.5",  64'h3FF8000000000000, 0, 0, 1, 1, 0, R(2, 0, 1, 0));
      step("p2.5",  64'h4004000000000000, 0, 0, 1, 1, 0, R(2, 0, 1, 0));
      step("n2.5m", 64'hC004000000000000, 3, 0, 1, 1, 0,
           R(64'hFFFF_FFFF_FFFF_FFFD, 0, 1, 0));
      step("n2.5z", 64'hC004000000000000, 1, 0, 1, 1, 0,
           R(64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0));
      step("p2e63", 64'h43E0000000000000, 0, 0, 1, 1, 0, R(PMAX, 1, 0, 0));
      step("n2e63", 64'hC3E0000000000000, 0, 0, 1, 1, 0, R(NMIN, 0, 0, 0));
      step("snan",  64'h7FF0000000000001, 0, 0, 1, 1, 0, R(PMAX, 1, 0, 1));
      step("qnan",  64'hFFF8000000000000, 0, 0, 1, 1, 0, R(PMAX, 1, 0, 0));
      step("pinf",  64'h7FF0000000000000, 0, 0, 1, 1, 0, R(PMAX, 1, 0, 0));
      step("ninf",  64'hFFF0000000000000, 0, 0, 1, 1, 0, R(NMIN, 1, 0, 0));
      step("u_n1",  64'hBFF0000000000000, 0, 1, 1, 1, 0, R(0, 1, 0, 0));
      step("u_n.25",64'hBFD0000000000000, 0, 1, 1, 1, 0, R(0, 0, 1, 0));
      step("u_2e63",64'h43E0000000000000, 0, 1, 1, 1, 0, R(NMIN, 0, 0, 0));
      step("u_2e64",64'h43F0000000000000, 0, 1, 1, 1, 0, R('1, 1, 0, 0));
      step("u_qnan",64'h7FF8000000000000, 0, 1, 1, 1, 0, R('1, 1, 0, 0));
      step("zero",  64'h0000000000000000, 0, 0, 1, 1, 0, NONE);
      step("nzero", 64'h8000000000000000, 0, 0, 1, 1, 0, NONE);
      step("p0.5",  64'h3FE0000000000000, 0, 0, 1, 1, 0, R(0, 0, 1, 0));
      step("p1.5up",64'h3FF8000000000000, 2, 0, 1, 1, 0, R(2, 0, 1, 0));
      step("p1.5dn",64'h3FF8000000000000, 3, 0, 1, 1, 0, R(1, 0, 1, 0));
      step("n1.5ne",64'hBFF8000000000000, 0, 0, 1, 1, 0,
           R(64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 0));
      step("drain0", 0, 0, 0, 0, 1, 0, NONE);
      step("drain1", 0, 0, 0, 0, 1, 0, NONE);

      // adv pattern 1,0,1,1 with back-to-back starts
      step("pipeA",  64'h4008000000000000, 0, 0, 1, 1, 0, R(3, 0, 0, 0));
      step("pipeB0", 64'h4014000000000000, 0, 0, 1, 0, 0, R(5, 0, 0, 0));
      step("pipeB1", 64'h4014000000000000, 0, 0, 1, 1, 0, R(5, 0, 0, 0));
      step("pipeC",  64'h401C000000000000, 0, 0, 1, 1, 0, R(7, 0, 0, 0));
      step("pipeD0", 0, 0, 0, 0, 1, 0, NONE);
      step("pipeD1", 0, 0, 0, 0, 1, 0, NONE);

      // flush kills the operand sitting in stage1
      step("flA",  64'h4008000000000000, 0, 0, 1, 1, 0, R(3, 0, 0, 0));
      step("flF",  0, 0, 0, 0, 1, 1, NONE);
      step("flI0", 0, 0, 0, 0, 1, 0, NONE);
      step("flI1", 0, 0, 0, 0, 1, 0, NONE);

      // asynchronous reset while a result is on the outputs
      step("rsE", 64'h4008000000000000, 0, 0, 1, 1, 0, R(3, 0, 0, 0));
      step("rsF", 64'h4014000000000000, 0, 0, 1, 1, 0, R(5, 0, 0, 0));
      rst = 1;
      #1;
      check("rst_async", {rdy, iv, inv, inx, snan}, 67'd0);
      q.delete();
      m_v1 = 0;
      m_rdy = 0;
      @(posedge clk); #1;
      rst = 0;
      step("rsI0", 0, 0, 0, 0, 1, 0, NONE);
      step("rsI1", 0, 0, 0, 0, 1, 0, NONE);
      adv = 0;

      // single precision to 32-bit integer
      step32("b_8388609", 32'h4B000001, 0, 0, 1, R(32'd8388609, 0, 0, 0));
      step32("b_2e31",    32'h4F000000, 0, 0, 1, R(32'h7FFFFFFF, 1, 0, 0));
      step32("b_denorm",  32'h00000001, 2, 0, 1, R(1, 0, 1, 0));
      step32("b_n2e31",   32'hCF000000, 0, 0, 1, R(32'h80000000, 0, 0, 0));
      step32("b_n2e31p",  32'hCF000001, 0, 0, 1, R(32'h80000000, 1, 0, 0));
      step32("b_qnan",    32'h7FC00000, 0, 0, 1, R(32'h7FFFFFFF, 1, 0, 0));
      step32("b_u2e32",   32'h4F800000, 0, 1, 1, R(32'hFFFFFFFF, 1, 0, 0));
      step32("b_umax",    32'h4F7FFFFF, 0, 1, 1, R(32'hFFFFFF00, 0, 0, 0));
      step32("b_drain0",  0, 0, 0, 0, NONE);
      step32("b_drain1",  0, 0, 0, 0, NONE);

      check("sb_empty", 67'(q.size() + qb.size()), 67'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
